// File: rtl/cd_host_comm.sv
// Host side of the 4-bit CDD bus: acks a drive IRQ, receives a 10-nibble status frame, then sends a 10-nibble command frame.
// Latency: 2-cycle input synchronizer plus 1 registered FSM cycle, so an input edge shows on the outputs 3 cycles later.
// Backpressure: the drive paces every nibble through CDCK; a stalled drive is abandoned after TIMEOUT cycles in one state.
module cd_host_comm #(
    parameter int TIMEOUT = 120000,
    parameter int SETUP   = 4
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        CDD_nIRQ,
    input  logic        CDCK,
    input  logic [3:0]  CDD_RXD,
    output logic        HOCK,
    output logic [3:0]  CDD_TXD,
    input  logic [35:0] CMD_DATA,
    output logic [35:0] STATUS_DATA,
    output logic        STAT_VALID,
    output logic        CHK_ERR,
    output logic        CMD_DONE,
    output logic        ABORT,
    output logic        BUSY
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RX_LO,
        RX_HI,
        TX_LO,
        TX_SET,
        TX_HI,
        DONE
    } state_t;

    // Strobe, IRQ and data share one synchronizer so a nibble is never sampled ahead of its strobe.
    logic [5:0] sync1;
    logic [5:0] sync2;
    logic       nirq_d;
    logic       nirq_s;
    logic       cdck_s;
    logic [3:0] rxd_s;
    logic       nirq_fall;

    assign nirq_s    = sync2[5];
    assign cdck_s    = sync2[4];
    assign rxd_s     = sync2[3:0];
    assign nirq_fall = nirq_d & ~nirq_s;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sync1  <= 6'b110000;
            sync2  <= 6'b110000;
            nirq_d <= 1'b1;
        end else begin
            sync1  <= {CDD_nIRQ, CDCK, CDD_RXD};
            sync2  <= sync1;
            nirq_d <= nirq_s;
        end
    end

    state_t        state, state_n;
    logic [3:0]    n, n_n;
    logic [3:0]    sum, sum_n;
    logic [35:0]   stat, stat_n;
    logic [35:0]   cmd, cmd_n;
    logic [3:0]    setup_cnt, setup_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          hock, hock_n;
    logic [3:0]    txd, txd_n;
    logic [35:0]   status, status_n;
    logic          stat_valid, stat_valid_n;
    logic          chk_err, chk_err_n;
    logic          cmd_done, cmd_done_n;
    logic          abort, abort_n;

    logic [3:0] cmd_sum;
    logic [3:0] tx_chk;

    always_comb begin
        cmd_sum = 4'd5;
        for (int i = 0; i < 9; i++) begin
            cmd_sum = cmd_sum + cmd[4*i +: 4];
        end
        tx_chk = ~cmd_sum;
    end

    always_comb begin
        state_n      = state;
        n_n          = n;
        sum_n        = sum;
        stat_n       = stat;
        cmd_n        = cmd;
        setup_n      = setup_cnt;
        hock_n       = hock;
        txd_n        = txd;
        status_n     = status;
        stat_valid_n = 1'b0;
        chk_err_n    = 1'b0;
        cmd_done_n   = 1'b0;
        abort_n      = 1'b0;

        // A fresh IRQ mid-frame wins over everything: drop the frame and ack the new one.
        if (state != IDLE && state != ACK && nirq_fall) begin
            abort_n = 1'b1;
            cmd_n   = CMD_DATA;
            hock_n  = 1'b0;
            state_n = ACK;
        end else if (state != IDLE && tmo == TW'(TIMEOUT - 1)) begin
            abort_n = 1'b1;
            hock_n  = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    hock_n = 1'b1;
                    if (nirq_fall) begin
                        cmd_n   = CMD_DATA;
                        hock_n  = 1'b0;
                        state_n = ACK;
                    end
                end
                ACK: begin
                    if (nirq_s) begin
                        n_n     = 4'd0;
                        sum_n   = 4'd5;
                        state_n = RX_LO;
                    end
                end
                RX_LO: begin
                    if (!cdck_s) begin
                        if (n < 4'd9) begin
                            stat_n[4*n +: 4] = rxd_s;
                        end
                        sum_n   = sum + rxd_s;
                        hock_n  = 1'b1;
                        state_n = RX_HI;
                    end
                end
                RX_HI: begin
                    if (cdck_s) begin
                        hock_n = 1'b0;
                        if (n == 4'd9) begin
                            n_n     = 4'd0;
                            state_n = TX_LO;
                        end else begin
                            n_n     = n + 4'd1;
                            state_n = RX_LO;
                        end
                    end
                end
                TX_LO: begin
                    if (!cdck_s) begin
                        if (n == 4'd9) begin
                            txd_n = tx_chk;
                        end else begin
                            txd_n = cmd[4*n +: 4];
                        end
                        setup_n = 4'd0;
                        state_n = TX_SET;
                    end
                end
                TX_SET: begin
                    if (setup_cnt == 4'(SETUP - 1)) begin
                        hock_n  = 1'b1;
                        state_n = TX_HI;
                    end else begin
                        setup_n = setup_cnt + 4'd1;
                    end
                end
                TX_HI: begin
                    if (cdck_s) begin
                        hock_n = 1'b0;
                        if (n == 4'd9) begin
                            state_n = DONE;
                        end else begin
                            n_n     = n + 4'd1;
                            state_n = TX_LO;
                        end
                    end
                end
                DONE: begin
                    cmd_done_n = 1'b1;
                    if (sum == 4'hF) begin
                        status_n     = stat;
                        stat_valid_n = 1'b1;
                    end else begin
                        chk_err_n = 1'b1;
                    end
                    hock_n  = 1'b1;
                    state_n = IDLE;
                end
                default: begin
                    hock_n  = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end

        // Progress is measured per state, so any transition restarts the watchdog.
        if (state_n != state || state == IDLE) begin
            tmo_n = '0;
        end else begin
            tmo_n = tmo + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            n          <= 4'd0;
            sum        <= 4'd0;
            stat       <= '0;
            cmd        <= '0;
            setup_cnt  <= 4'd0;
            tmo        <= '0;
            hock       <= 1'b1;
            txd        <= 4'd0;
            status     <= '0;
            stat_valid <= 1'b0;
            chk_err    <= 1'b0;
            cmd_done   <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_n;
            n          <= n_n;
            sum        <= sum_n;
            stat       <= stat_n;
            cmd        <= cmd_n;
            setup_cnt  <= setup_n;
            tmo        <= tmo_n;
            hock       <= hock_n;
            txd        <= txd_n;
            status     <= status_n;
            stat_valid <= stat_valid_n;
            chk_err    <= chk_err_n;
            cmd_done   <= cmd_done_n;
            abort      <= abort_n;
        end
    end

    assign HOCK        = hock;
    assign CDD_TXD     = txd;
    assign STATUS_DATA = status;
    assign STAT_VALID  = stat_valid;
    assign CHK_ERR     = chk_err;
    assign CMD_DONE    = cmd_done;
    assign ABORT       = abort;
    assign BUSY        = (state != IDLE);

endmodule

// File: tb/tb_cd_host_comm.sv
// Directed bench for cd_host_comm: a behavioural drive MCU exchanges frames and each scenario checks its own results.
module tb_cd_host_comm;

    localparam int TIMEOUT = 200;
    localparam int SETUP   = 4;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic        CDD_nIRQ;
    logic        CDCK;
    logic [3:0]  CDD_RXD;
    logic        HOCK;
    logic [3:0]  CDD_TXD;
    logic [35:0] CMD_DATA;
    logic [35:0] STATUS_DATA;
    logic        STAT_VALID;
    logic        CHK_ERR;
    logic        CMD_DONE;
    logic        ABORT;
    logic        BUSY;

    cd_host_comm #(.TIMEOUT(TIMEOUT), .SETUP(SETUP)) dut (
        .clk_sys(clk_sys),
        .RESET(RESET),
        .CDD_nIRQ(CDD_nIRQ),
        .CDCK(CDCK),
        .CDD_RXD(CDD_RXD),
        .HOCK(HOCK),
        .CDD_TXD(CDD_TXD),
        .CMD_DATA(CMD_DATA),
        .STATUS_DATA(STATUS_DATA),
        .STAT_VALID(STAT_VALID),
        .CHK_ERR(CHK_ERR),
        .CMD_DONE(CMD_DONE),
        .ABORT(ABORT),
        .BUSY(BUSY)
    );

    always #5 clk_sys = ~clk_sys;

    int tests_run    = 0;
    int tests_failed = 0;

    // Pulse counters and TXD-stability tracking, sampled on the falling edge.
    int         n_stat = 0, n_chk = 0, n_done = 0, n_abort = 0, n_coinc = 0;
    int         stable_cnt = 0, setup_seen = 0;
    logic       hock_prev = 1'b1;
    logic [3:0] txd_prev = 4'd0;

    always @(negedge clk_sys) begin
        if (STAT_VALID) n_stat++;
        if (CHK_ERR) n_chk++;
        if (CMD_DONE) n_done++;
        if (ABORT) n_abort++;
        if (STAT_VALID && CMD_DONE) n_coinc++;
        if (CDD_TXD !== txd_prev) stable_cnt = 1;
        else stable_cnt++;
        if (HOCK && !hock_prev) setup_seen = stable_cnt;
        hock_prev = HOCK;
        txd_prev  = CDD_TXD;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_hock(input logic v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (HOCK === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_irq(output bit ok);
        @(negedge clk_sys);
        CDD_nIRQ = 1'b0;
        wait_hock(1'b0, ok);
        CDD_nIRQ = 1'b1;
    endtask

    task automatic rx_part(input logic [39:0] st, output bit ok);
        bit w;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            CDD_RXD = st[4*k +: 4];
            CDCK    = 1'b0;
            wait_hock(1'b1, w);
            if (!w) begin ok = 1'b0; return; end
            CDCK = 1'b1;
            wait_hock(1'b0, w);
            if (!w) begin ok = 1'b0; return; end
        end
    endtask

    task automatic tx_part(input int cnt, output logic [39:0] rx, output bit ok, output bit setup_ok);
        bit w;
        ok       = 1'b1;
        setup_ok = 1'b1;
        rx       = '0;
        for (int k = 0; k < cnt; k++) begin
            CDCK = 1'b0;
            wait_hock(1'b1, w);
            if (!w) begin ok = 1'b0; return; end
            #1;
            rx[4*k +: 4] = CDD_TXD;
            if (setup_seen < SETUP + 1) setup_ok = 1'b0;
            if (k == cnt - 1 && cnt < 10) return;
            CDCK = 1'b1;
            wait_hock(1'b0, w);
            if (!w) begin ok = 1'b0; return; end
        end
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        CDD_nIRQ = 1'b1;
        CDCK     = 1'b1;
        CDD_RXD  = 4'd0;
        CMD_DATA = '0;
        repeat (3) @(negedge clk_sys);
        tests_run++;
        if (HOCK !== 1'b1) begin tests_failed++; $display("FAIL reset_hock: got %b expected 1", HOCK); end
        RESET = 1'b0;
        repeat (4) @(negedge clk_sys);
        tests_run++;
        if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tests_run++;
        if ({STAT_VALID, CHK_ERR, CMD_DONE, ABORT} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_pulses: got %b expected 0000", {STAT_VALID, CHK_ERR, CMD_DONE, ABORT});
        end
        tests_run++;
        if (STATUS_DATA !== 36'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected 0", STATUS_DATA); end
        tests_run++;
        if (CDD_TXD !== 4'h0 || HOCK !== 1'b1) begin
            tests_failed++; $display("FAIL reset_txd_hock: got txd=%h hock=%b expected 0/1", CDD_TXD, HOCK);
        end
    endtask

    task automatic test_good_frame();
        bit ok, ok2, ok3, sok;
        logic [39:0] rx;
        int s0, d0, c0, a0, k0;
        s0 = n_stat; d0 = n_done; c0 = n_chk; a0 = n_abort; k0 = n_coinc;
        CMD_DATA = 36'h000021003;
        drive_irq(ok);
        rx_part(40'hA054321001, ok2);
        tx_part(10, rx, ok3, sok);
        repeat (3) @(negedge clk_sys);
        #1;
        tests_run++;
        if (!(ok && ok2 && ok3)) begin tests_failed++; $display("FAIL good_handshake: got %b%b%b expected 111", ok, ok2, ok3); end
        tests_run++;
        if (rx !== 40'h4000021003) begin tests_failed++; $display("FAIL good_tx_nibbles: got %h expected 4000021003", rx); end
        tests_run++;
        if (STATUS_DATA !== 36'h054321001) begin tests_failed++; $display("FAIL good_status: got %h expected 054321001", STATUS_DATA); end
        tests_run++;
        if (n_stat - s0 != 1 || n_done - d0 != 1) begin
            tests_failed++; $display("FAIL good_pulses: got stat=%0d done=%0d expected 1/1", n_stat - s0, n_done - d0);
        end
        tests_run++;
        if (n_chk - c0 != 0 || n_abort - a0 != 0) begin
            tests_failed++; $display("FAIL good_no_err: got chk=%0d abort=%0d expected 0/0", n_chk - c0, n_abort - a0);
        end
        tests_run++;
        if (n_coinc - k0 != 1) begin tests_failed++; $display("FAIL good_same_cycle: got %0d expected 1", n_coinc - k0); end
        tests_run++;
        if (!sok) begin tests_failed++; $display("FAIL good_setup: got setup=%0d expected >=%0d", setup_seen, SETUP + 1); end
        tests_run++;
        if (BUSY !== 1'b0 || HOCK !== 1'b1) begin
            tests_failed++; $display("FAIL good_idle: got busy=%b hock=%b expected 0/1", BUSY, HOCK);
        end
    endtask

    task automatic test_bad_checksum();
        bit ok, ok2, ok3, sok;
        logic [39:0] rx;
        int s0, d0, c0;
        s0 = n_stat; d0 = n_done; c0 = n_chk;
        CMD_DATA = 36'h0;
        drive_irq(ok);
        rx_part(40'hB054321001, ok2);
        tx_part(10, rx, ok3, sok);
        repeat (3) @(negedge clk_sys);
        #1;
        tests_run++;
        if (!(ok && ok2 && ok3)) begin tests_failed++; $display("FAIL bad_handshake: got %b%b%b expected 111", ok, ok2, ok3); end
        tests_run++;
        if (rx !== 40'hA000000000) begin tests_failed++; $display("FAIL bad_tx_nibbles: got %h expected A000000000", rx); end
        tests_run++;
        if (n_chk - c0 != 1 || n_stat - s0 != 0) begin
            tests_failed++; $display("FAIL bad_pulses: got chk=%0d stat=%0d expected 1/0", n_chk - c0, n_stat - s0);
        end
        tests_run++;
        if (n_done - d0 != 1) begin tests_failed++; $display("FAIL bad_cmd_done: got %0d expected 1", n_done - d0); end
        tests_run++;
        if (STATUS_DATA !== 36'h054321001) begin tests_failed++; $display("FAIL bad_status_kept: got %h expected 054321001", STATUS_DATA); end
    endtask

    task automatic test_timeout();
        bit ok, idle;
        int a0, d0, cyc;
        a0 = n_abort; d0 = n_done;
        drive_irq(ok);
        idle = 1'b0;
        cyc  = 0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(negedge clk_sys);
            cyc++;
            if (cyc == TIMEOUT / 2) begin
                tests_run++;
                if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL tmo_early: got busy=%b expected 1", BUSY); end
            end
            if (BUSY === 1'b0) begin idle = 1'b1; break; end
        end
        #1;
        tests_run++;
        if (!ok || !idle || cyc < TIMEOUT || cyc > TIMEOUT + 10) begin
            tests_failed++; $display("FAIL tmo_return: got ack=%b idle=%b cycles=%0d expected 1/1/%0d..%0d", ok, idle, cyc, TIMEOUT, TIMEOUT + 10);
        end
        tests_run++;
        if (n_abort - a0 != 1) begin tests_failed++; $display("FAIL tmo_abort: got %0d expected 1", n_abort - a0); end
        tests_run++;
        if (HOCK !== 1'b1) begin tests_failed++; $display("FAIL tmo_hock: got %b expected 1", HOCK); end
        tests_run++;
        if (n_done - d0 != 0) begin tests_failed++; $display("FAIL tmo_no_done: got %0d expected 0", n_done - d0); end
    endtask

    task automatic test_restart();
        bit ok, ok2, ok3, ok4, ok5, sok;
        logic [39:0] rx;
        int a0, d0, s0;
        a0 = n_abort; d0 = n_done; s0 = n_stat;
        CMD_DATA = 36'h000021003;
        drive_irq(ok);
        rx_part(40'hA054321001, ok2);
        tx_part(5, rx, ok3, sok);
        CMD_DATA = 36'h000000007;
        CDD_nIRQ = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1;
        tests_run++;
        if (HOCK !== 1'b0 || BUSY !== 1'b1) begin
            tests_failed++; $display("FAIL restart_ack: got hock=%b busy=%b expected 0/1", HOCK, BUSY);
        end
        tests_run++;
        if (n_abort - a0 != 1) begin tests_failed++; $display("FAIL restart_abort: got %0d expected 1", n_abort - a0); end
        CDD_nIRQ = 1'b1;
        CDCK     = 1'b1;
        CMD_DATA = 36'h0;
        rx_part(40'hA054321001, ok4);
        tx_part(10, rx, ok5, sok);
        repeat (3) @(negedge clk_sys);
        #1;
        tests_run++;
        if (!(ok && ok2 && ok3 && ok4 && ok5)) begin
            tests_failed++; $display("FAIL restart_handshake: got %b%b%b%b%b expected 11111", ok, ok2, ok3, ok4, ok5);
        end
        tests_run++;
        if (rx !== 40'h3000000007) begin tests_failed++; $display("FAIL restart_tx_nibbles: got %h expected 3000000007", rx); end
        tests_run++;
        if (n_done - d0 != 1 || n_stat - s0 != 1) begin
            tests_failed++; $display("FAIL restart_pulses: got done=%0d stat=%0d expected 1/1", n_done - d0, n_stat - s0);
        end
    endtask

    task automatic test_cmd_change();
        bit ok, ok2, ok3, sok;
        logic [39:0] rx;
        int d0;
        d0 = n_done;
        CMD_DATA = 36'h123456789;
        drive_irq(ok);
        CMD_DATA = 36'hFFFFFFFFF;
        rx_part(40'hA054321001, ok2);
        tx_part(10, rx, ok3, sok);
        repeat (3) @(negedge clk_sys);
        #1;
        tests_run++;
        if (!(ok && ok2 && ok3)) begin tests_failed++; $display("FAIL chg_handshake: got %b%b%b expected 111", ok, ok2, ok3); end
        tests_run++;
        if (rx !== 40'hD123456789) begin tests_failed++; $display("FAIL chg_tx_nibbles: got %h expected D123456789", rx); end
        tests_run++;
        if (n_done - d0 != 1) begin tests_failed++; $display("FAIL chg_cmd_done: got %0d expected 1", n_done - d0); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_restart();
        test_cmd_change();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
